iir_tdm_sched: RTL and testbench

//  Time-multiplexed direct-form IIR engine controller. Shares one signed multiplier/accumulator

---
 rtl/iir_sched_pkg.sv | 28 ++
 rtl/iir_mac.sv | 44 ++++
 rtl/iir_tdm_sched.sv | 197 +++++++++++++++++++
 tb/tb_iir_tdm_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_sched_pkg.sv
// Shared definitions for the time-multiplexed IIR engine: default sizes,
// coefficient address map and the scheduler state encoding.
package iir_sched_pkg;

  // Default configuration shared with the other IIR blocks.
  localparam int DEF_CH    = 2;   // channels
  localparam int DEF_NB    = 5;   // zero taps b0..b(NB-1)
  localparam int DEF_NA    = 4;   // pole taps a1..aNA
  localparam int DEF_DW    = 12;  // sample width
  localparam int DEF_CW    = 12;  // coefficient width
  localparam int DEF_AW    = 26;  // accumulator width
  localparam int DEF_SHIFT = 9;   // output scaling shift

  // Coefficient bank address map: b taps first, then a taps.
  localparam int B_BASE = 0;
  localparam int A_BASE = B_BASE + DEF_NB;

  // Scheduler states, one pass per accepted sample.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC_B,
    MAC_A,
    SCALE,
    OUT
  } state_t;

endpackage

// File: rtl/iir_mac.sv
// Shared signed multiply-accumulate unit. One DWxCW product per enabled
// cycle is added to (or subtracted from) a wrapping AW-bit accumulator.
// The scaled view of the accumulator is the filter output.
module iir_mac #(
  parameter int DW    = 12,
  parameter int CW    = 12,
  parameter int AW    = 26,
  parameter int SHIFT = 9
) (
  input  logic                 clk,
  input  logic                 rst,       // asynchronous, active-low
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic                 i_sub,
  input  logic signed [DW-1:0] i_a,
  input  logic signed [CW-1:0] i_b,
  output logic signed [DW-1:0] o_scaled
);

  localparam int PW = DW + CW;

  logic signed [PW-1:0] w_prod;
  logic signed [AW-1:0] w_prod_ext;
  logic signed [AW-1:0] r_acc;

  // Size casts on signed operands sign-extend, so this is a full signed product.
  assign w_prod     = PW'(i_a) * PW'(i_b);
  assign w_prod_ext = AW'(w_prod);

  // Accumulator: clear on LOAD, add b-terms, subtract a-terms, wrap mod 2^AW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_sub ? (r_acc - w_prod_ext) : (r_acc + w_prod_ext);
    end
  end

  // Arithmetic right shift then truncation to DW bits is a plain slice.
  assign o_scaled = r_acc[SHIFT +: DW];

endmodule

// File: rtl/iir_tdm_sched.sv
// Time-multiplexed direct-form IIR controller. One sample at a time walks
// LOAD -> MAC_B -> MAC_A -> SCALE -> OUT through the shared iir_mac, using
// the per-channel x/y histories and a shared coefficient bank.
module iir_tdm_sched
  import iir_sched_pkg::*;
#(
  parameter int CH    = DEF_CH,
  parameter int NB    = DEF_NB,
  parameter int NA    = DEF_NA,
  parameter int DW    = DEF_DW,
  parameter int CW    = DEF_CW,
  parameter int AW    = DEF_AW,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic                          clk,
  input  logic                          rst,        // asynchronous, active-low
  input  logic                          in_valid,
  input  logic [$clog2(CH)-1:0]         in_ch,
  input  logic signed [DW-1:0]          in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [$clog2(CH)-1:0]         out_ch,
  output logic signed [DW-1:0]          out_data,
  input  logic                          coef_we,
  input  logic [$clog2(NB+NA)-1:0]      coef_addr,
  input  logic signed [CW-1:0]          coef_data,
  output logic                          busy
);

  localparam int CHW   = $clog2(CH);
  localparam int NC    = NB + NA;
  localparam int CAW   = $clog2(NC);
  localparam int TW    = $clog2(NC);
  localparam int A_OFS = B_BASE + NB;

  state_t                r_state;
  logic [TW-1:0]         r_tap;
  logic [CHW-1:0]        r_ch;
  logic signed [DW-1:0]  r_x_in;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_out_valid;
  logic [CHW-1:0]        r_out_ch;
  logic signed [DW-1:0]  r_out_data;

  logic signed [CW-1:0]  r_coef [NC];
  logic signed [DW-1:0]  r_xh   [CH][NB];   // index 0 = x[n]
  logic signed [DW-1:0]  r_yh   [CH][NA];   // index 0 = y[n-1]

  logic                  w_ch_ok;
  logic [CHW:0]          w_ch_ext;
  logic signed [DW-1:0]  w_mul_a;
  logic signed [CW-1:0]  w_mul_b;
  logic signed [DW-1:0]  w_scaled;

  // Out-of-range channels are accepted but never processed.
  assign w_ch_ext = {1'b0, in_ch};
  assign w_ch_ok  = (w_ch_ext < (CHW+1)'(CH));

  // Operand mux: the tap counter selects history sample and coefficient.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    for (int k = 0; k < NB; k++) begin
      if (r_state == MAC_B && r_tap == TW'(k)) begin
        w_mul_a = r_xh[r_ch][k];
        w_mul_b = r_coef[B_BASE + k];
      end
    end
    for (int k = 0; k < NA; k++) begin
      if (r_state == MAC_A && r_tap == TW'(k)) begin
        w_mul_a = r_yh[r_ch][k];
        w_mul_b = r_coef[A_OFS + k];
      end
    end
  end

  iir_mac #(
    .DW    (DW),
    .CW    (CW),
    .AW    (AW),
    .SHIFT (SHIFT)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (r_state == LOAD),
    .i_en     (r_state == MAC_B || r_state == MAC_A),
    .i_sub    (r_state == MAC_A),
    .i_a      (w_mul_a),
    .i_b      (w_mul_b),
    .o_scaled (w_scaled)
  );

  // Scheduler FSM with registered handshake and result outputs.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_tap       <= '0;
      r_ch        <= '0;
      r_x_in      <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_ch   <= in_ch;
            r_x_in <= in_data;
            if (w_ch_ok) begin
              r_state    <= LOAD;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end
        LOAD: begin
          r_tap   <= '0;
          r_state <= MAC_B;
        end
        MAC_B: begin
          if (r_tap == TW'(NB - 1)) begin
            r_tap   <= '0;
            r_state <= MAC_A;
          end else begin
            r_tap <= r_tap + 1'b1;
          end
        end
        MAC_A: begin
          if (r_tap == TW'(NA - 1)) begin
            r_tap   <= '0;
            r_state <= SCALE;
          end else begin
            r_tap <= r_tap + 1'b1;
          end
        end
        SCALE: begin
          r_state     <= OUT;
          r_out_valid <= 1'b1;
          r_out_ch    <= r_ch;
          r_out_data  <= w_scaled;
        end
        OUT: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel histories: x shifts on LOAD, y shifts on OUT.
  // NOTE: these small flop arrays must power up as a clean filter state, so they take the reset like any register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < NB; k++) r_xh[c][k] <= '0;
        for (int k = 0; k < NA; k++) r_yh[c][k] <= '0;
      end
    end else if (r_state == LOAD) begin
      for (int k = NB - 1; k > 0; k--) r_xh[r_ch][k] <= r_xh[r_ch][k-1];
      r_xh[r_ch][0] <= r_x_in;
    end else if (r_state == OUT) begin
      for (int k = NA - 1; k > 0; k--) r_yh[r_ch][k] <= r_yh[r_ch][k-1];
      r_yh[r_ch][0] <= r_out_data;
    end
  end

  // Coefficient bank: identity filter at reset, writable only while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NC; k++) r_coef[k] <= '0;
      r_coef[B_BASE] <= CW'(1 << SHIFT);
    end else if (r_state == IDLE && coef_we) begin
      for (int k = 0; k < NC; k++) begin
        if (coef_addr == CAW'(k)) r_coef[k] <= coef_data;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_iir_tdm_sched.sv
// Self-checking bench for iir_tdm_sched. A behavioural model computes each
// output with plain integer sums over per-channel histories and predicts the
// handshake timing from the fixed per-sample cycle budget; a compare process
// checks the DUT against it on every falling edge.
module tb_iir_tdm_sched;
  import iir_sched_pkg::*;

  localparam int CHW = $clog2(DEF_CH);
  localparam int NC  = DEF_NB + DEF_NA;
  // Busy cycles per sample: LOAD + NB + NA + SCALE + OUT.
  localparam int BUSY_CYC = DEF_NB + DEF_NA + 3;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic [CHW-1:0]           in_ch;
  logic signed [DEF_DW-1:0] in_data;
  logic                     in_ready;
  logic                     out_valid;
  logic [CHW-1:0]           out_ch;
  logic signed [DEF_DW-1:0] out_data;
  logic                     coef_we;
  logic [$clog2(NC)-1:0]    coef_addr;
  logic signed [DEF_CW-1:0] coef_data;
  logic                     busy;

  iir_tdm_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // ---------------- behavioural model ----------------
  int cyc;
  bit m_active;
  int m_last_acc;
  bit m_accepted;
  int m_coef [NC];
  int m_xh [DEF_CH][DEF_NB];
  int m_yh [DEF_CH][DEF_NA];
  int pend_ch, pend_y;
  bit exp_valid, exp_ready;
  int exp_ch, exp_data;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc        = 0;
    m_active   = 0;
    m_last_acc = 0;
    m_accepted = 0;
    for (int k = 0; k < NC; k++) m_coef[k] = 0;
    m_coef[B_BASE] = 1 << DEF_SHIFT;
    for (int c = 0; c < DEF_CH; c++) begin
      for (int k = 0; k < DEF_NB; k++) m_xh[c][k] = 0;
      for (int k = 0; k < DEF_NA; k++) m_yh[c][k] = 0;
    end
    exp_valid = 0;
    exp_ready = 1;
    exp_ch    = 0;
    exp_data  = 0;
  endtask

  // y = (sum b_k x[n-k] - sum a_k y[n-k]) >>> SHIFT, keeping the low DW bits.
  function automatic int model_y(input int ch, input int x);
    longint acc;
    logic [63:0] bits;
    logic signed [DEF_DW-1:0] y;
    for (int k = DEF_NB - 1; k > 0; k--) m_xh[ch][k] = m_xh[ch][k-1];
    m_xh[ch][0] = x;
    acc = 0;
    for (int k = 0; k < DEF_NB; k++) acc += longint'(m_coef[B_BASE + k]) * m_xh[ch][k];
    for (int k = 0; k < DEF_NA; k++) acc -= longint'(m_coef[A_BASE + k]) * m_yh[ch][k];
    bits = 64'(acc);
    y = bits[DEF_SHIFT +: DEF_DW];
    for (int k = DEF_NA - 1; k > 0; k--) m_yh[ch][k] = m_yh[ch][k-1];
    m_yh[ch][0] = int'(y);
    return int'(y);
  endfunction

  // Advance the model by one rising edge using the inputs applied before it.
  task automatic model_edge();
    int e;
    bit idle;
    m_accepted = 0;
    if (rst !== 1'b1) return;
    e    = cyc + 1;
    cyc  = e;
    idle = !m_active || (e > m_last_acc + BUSY_CYC);
    if (idle && coef_we && int'(coef_addr) < NC) m_coef[coef_addr] = int'(coef_data);
    if (idle && in_valid) begin
      m_accepted = 1;
      if (int'(in_ch) < DEF_CH) begin
        m_active   = 1;
        m_last_acc = e;
        pend_ch    = int'(in_ch);
        pend_y     = model_y(int'(in_ch), int'(in_data));
      end
    end
    exp_valid = m_active && (e == m_last_acc + BUSY_CYC - 1);
    if (exp_valid) begin
      exp_ch   = pend_ch;
      exp_data = pend_y;
    end
    exp_ready = !m_active || (e >= m_last_acc + BUSY_CYC);
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("in_ready",  in_ready,  exp_ready);
      check("busy",      busy,      !exp_ready);
      check("out_valid", out_valid, exp_valid);
      check("out_ch",    out_ch,    exp_ch);
      check("out_data",  out_data,  exp_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic reset_dut();
    in_valid = 0;
    coef_we  = 0;
    rst      = 0;
    model_reset();
    tick();
    tick();
    rst = 1;
    tick();
  endtask

  task automatic write_coef(input int addr, input int data);
    coef_we   = 1;
    coef_addr = 4'(addr);
    coef_data = 12'(data);
    tick();
    coef_we = 0;
  endtask

  task automatic send(input int ch, input int x);
    bit ok;
    ok       = 0;
    in_valid = 1;
    in_ch    = CHW'(ch);
    in_data  = 12'(x);
    for (int n = 0; n < 40; n++) begin
      tick();
      if (m_accepted) begin
        ok = 1;
        break;
      end
    end
    in_valid = 0;
    check("send_accepted", ok, 1);
  endtask

  // Wait for the result strobe, compare it with a hand-computed value, then
  // step one more cycle into IDLE.
  task automatic wait_out(input string name, input int ch, input int exp_y, output int lat);
    bit found;
    found = 0;
    lat   = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (out_valid === 1'b1) begin
        found = 1;
        lat   = n;
        break;
      end
    end
    check({name, "_seen"}, found, 1);
    if (found) begin
      check({name, "_ch"}, out_ch, ch);
      check({name, "_y"},  out_data, exp_y);
      tick();
      check({name, "_ready_after"}, in_ready, 1);
    end
  endtask

  task automatic run(input string name, input int ch, input int x, input int exp_y);
    int lat;
    send(ch, x);
    wait_out(name, ch, exp_y, lat);
  endtask

  // ---------------- directed and random tests ----------------
  initial begin
    int lat;
    bit ok;
    rst       = 0;
    in_valid  = 0;
    in_ch     = '0;
    in_data   = '0;
    coef_we   = 0;
    coef_addr = '0;
    coef_data = '0;
    model_reset();

    // Test 1: identity after reset, latency and reset values.
    reset_dut();
    check("t1_rst_ready", in_ready, 1);
    check("t1_rst_busy", busy, 0);
    check("t1_rst_out_data", out_data, 0);
    check("t1_rst_out_ch", out_ch, 0);
    send(0, 100);
    wait_out("t1", 0, 100, lat);
    // Accepting edge closes cycle T; the strobe is visible from edge T+11, i.e. in cycle T+12.
    check("t1_latency_edges", lat, 11);

    // Test 2: FIR b0=b1=256.
    reset_dut();
    write_coef(0, 256);
    write_coef(1, 256);
    run("t2_s0", 0, 512, 256);
    run("t2_s1", 0, 0, 256);
    run("t2_s2", 0, 0, 0);

    // Test 3: single pole, b0=512, a1=-256.
    reset_dut();
    write_coef(0, 512);
    write_coef(A_BASE, -256);
    run("t3_s0", 0, 512, 512);
    run("t3_s1", 0, 0, 256);
    run("t3_s2", 0, 0, 128);
    run("t3_s3", 0, 0, 64);
    run("t3_s4", 0, 0, 32);

    // Test 4: same config, ch0 impulse interleaved with ch1 constant 100.
    reset_dut();
    write_coef(0, 512);
    write_coef(A_BASE, -256);
    run("t4_c0_0", 0, 512, 512);
    run("t4_c1_0", 1, 100, 100);
    run("t4_c0_1", 0, 0, 256);
    run("t4_c1_1", 1, 100, 150);
    run("t4_c0_2", 0, 0, 128);
    run("t4_c1_2", 1, 100, 175);
    run("t4_c0_3", 0, 0, 64);
    run("t4_c1_3", 1, 100, 187);

    // Test 5: sample and coef write offered while busy.
    reset_dut();
    send(0, 300);
    tick();
    tick();
    tick();
    check("t5_ready_while_busy", in_ready, 0);
    check("t5_busy", busy, 1);
    in_valid  = 1;
    in_ch     = 1'b1;
    in_data   = -12'sd77;
    coef_we   = 1;
    coef_addr = 4'd0;
    coef_data = 12'sd0;
    tick();
    coef_we = 0;
    wait_out("t5_first", 0, 300, lat);
    ok = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (m_accepted) begin
        ok = 1;
        break;
      end
    end
    in_valid = 0;
    check("t5_held_sample_accepted", ok, 1);
    wait_out("t5_second", 1, -77, lat);

    // Test 6: reset during MAC_B aborts and restores everything.
    reset_dut();
    write_coef(1, 256);
    write_coef(A_BASE, -256);
    run("t6_pre", 0, 1000, 1000);
    send(0, 500);
    tick();
    tick();
    rst = 0;
    model_reset();
    #1;
    check("t6_abort_valid", out_valid, 0);
    check("t6_abort_busy", busy, 0);
    check("t6_abort_ready", in_ready, 1);
    check("t6_abort_out_data", out_data, 0);
    tick();
    tick();
    rst = 1;
    tick();
    run("t6_post", 0, -2048, -2048);

    // Random traffic: held samples, random channels/data, coef writes at any time.
    reset_dut();
    for (int t = 0; t < 4000; t++) begin
      if (!in_valid && $urandom_range(0, 2) == 0) begin
        in_valid = 1;
        in_ch    = CHW'($urandom_range(0, DEF_CH - 1));
        in_data  = 12'($urandom);
      end
      coef_we   = ($urandom_range(0, 5) == 0);
      coef_addr = 4'($urandom_range(0, 15));
      coef_data = 12'($urandom);
      tick();
      if (m_accepted) in_valid = 0;
    end
    in_valid = 0;
    coef_we  = 0;
    repeat (BUSY_CYC + 2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
